// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// bus_arbiter_if : request/grant bundle between the bus arbiter and its masters
// Rev 1.0
// ============================================================================
interface bus_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int OWNERW = 2
);
  logic [NREQ-1:0]   req;
  logic              bus_busy;
  logic [NREQ-1:0]   grant;
  logic              grant_valid;
  logic [OWNERW-1:0] owner;
  logic              bus_idle;
  logic              timeout_pulse;

  modport master (
    input  req,
    input  bus_busy,
    output grant,
    output grant_valid,
    output owner,
    output bus_idle,
    output timeout_pulse
  );

  modport slave (
    output req,
    output bus_busy,
    input  grant,
    input  grant_valid,
    input  owner,
    input  bus_idle,
    input  timeout_pulse
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : round-robin bus tenure arbiter with grant-acceptance timeout
// Rev 1.0
// ============================================================================
module bus_arbiter #(
  parameter int NREQ          = 4,
  parameter int OWNERW        = 2,
  parameter int TIMEOUTW      = 4,
  parameter int GRANT_TIMEOUT = 8
) (
  input  wire logic     clk,
  input  wire logic     reset,
  bus_arbiter_if.master arb_if
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWNED   = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam logic [OWNERW:0]     NREQ_EXT  = (OWNERW+1)'(NREQ);
  localparam logic [OWNERW-1:0]   OWNER_MAX = OWNERW'(NREQ - 1);
  localparam logic [TIMEOUTW-1:0] TO_LAST   = TIMEOUTW'(GRANT_TIMEOUT - 1);
  localparam logic [TIMEOUTW-1:0] TO_WARN   = TIMEOUTW'(GRANT_TIMEOUT - 2);

  state_e              state_q;
  logic [NREQ-1:0]     grant_q;
  logic [OWNERW-1:0]   owner_q;
  logic [OWNERW-1:0]   ptr_q;
  logic [TIMEOUTW-1:0] cnt_q;
  logic                timeout_q;

  logic                found_d;
  logic [OWNERW-1:0]   owner_d;
  logic [NREQ-1:0]     grant_d;
  logic [OWNERW-1:0]   ptr_d;
  logic [OWNERW:0]     cand;
  logic                owner_req;

  // Scan from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    found_d = 1'b0;
    owner_d = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (OWNERW+1)'(i);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (arb_if.req[cand[OWNERW-1:0]]) begin
        found_d = 1'b1;
        owner_d = cand[OWNERW-1:0];
      end
    end
  end

  assign grant_d   = NREQ'(1) << owner_d;
  assign ptr_d     = (owner_q == OWNER_MAX) ? '0 : owner_q + OWNERW'(1);
  assign owner_req = arb_if.req[owner_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!arb_if.bus_busy && found_d) begin
            owner_q <= owner_d;
            grant_q <= grant_d;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          cnt_q <= cnt_q + TIMEOUTW'(1);
          if (arb_if.bus_busy) begin
            state_q <= OWNED;
          end else if (!owner_req) begin
            grant_q <= '0;
            state_q <= RELEASE;
          end else if (cnt_q == TO_LAST) begin
            grant_q <= '0;
            state_q <= RELEASE;
          end else if (cnt_q == TO_WARN) begin
            // Registered pulse must already be high in the final grant cycle.
            timeout_q <= 1'b1;
          end
        end
        OWNED: begin
          if (!arb_if.bus_busy) begin
            grant_q <= '0;
            state_q <= RELEASE;
          end
        end
        RELEASE: begin
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arb_if.grant         = grant_q;
  assign arb_if.grant_valid   = |grant_q;
  assign arb_if.owner         = owner_q;
  assign arb_if.bus_idle      = (state_q == IDLE) && !arb_if.bus_busy;
  assign arb_if.timeout_pulse = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_bus_arbiter : directed self-checking bench for bus_arbiter
// Rev 1.0
// ============================================================================
module tb_bus_arbiter;

  localparam int NREQ          = 4;
  localparam int OWNERW        = 2;
  localparam int TIMEOUTW      = 4;
  localparam int GRANT_TIMEOUT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_order [5] = '{0, 1, 2, 3, 0};

  bus_arbiter_if #(.NREQ(NREQ), .OWNERW(OWNERW)) bif ();

  bus_arbiter #(
    .NREQ          (NREQ),
    .OWNERW        (OWNERW),
    .TIMEOUTW      (TIMEOUTW),
    .GRANT_TIMEOUT (GRANT_TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .arb_if (bif)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int gap;
    int hi;
    int pulse_at;
    int pulses;
    int nz;

    bif.req      = '0;
    bif.bus_busy = 1'b0;
    reset        = 1'b0;
    step(2);
    check_eq("rst_grant",   bif.grant, 0);
    check_eq("rst_valid",   bif.grant_valid, 0);
    check_eq("rst_owner",   bif.owner, 0);
    check_eq("rst_timeout", bif.timeout_pulse, 0);
    check_eq("rst_idle",    bif.bus_idle, 1);
    check_eq("rst_ptr",     32'(dut.ptr_q), 0);
    reset = 1'b1;
    step(1);

    // single requester, 4-cycle tenure
    bif.req = 4'b0010;
    step(1);
    check_eq("t1_grant", bif.grant, 4'b0010);
    check_eq("t1_owner", bif.owner, 1);
    check_eq("t1_valid", bif.grant_valid, 1);
    bif.bus_busy = 1'b1;
    step(4);
    check_eq("t1_hold", bif.grant, 4'b0010);
    check_eq("t1_state_owned", 32'(dut.state_q), 2);
    bif.bus_busy = 1'b0;
    bif.req      = '0;
    step(1);
    check_eq("t1_release", bif.grant, 0);
    check_eq("t1_rel_valid", bif.grant_valid, 0);
    step(1);
    check_eq("t1_ptr", 32'(dut.ptr_q), 2);
    check_eq("t1_idle", bif.bus_idle, 1);

    // round robin with all requesters; restart from ptr 0
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    bif.req = 4'b1111;
    step(1);
    for (int k = 0; k < 5; k++) begin
      gap = 0;
      while (bif.grant == 0 && gap < 10) begin
        gap++;
        step(1);
      end
      check_eq("rr_grant", bif.grant, 32'(1) << exp_order[k]);
      check_eq("rr_owner", bif.owner, exp_order[k]);
      if (k > 0) check_eq("rr_gap", gap, 2);
      bif.bus_busy = 1'b1;
      step(2);
      bif.bus_busy = 1'b0;
      if (k == 4) bif.req = '0;
      step(1);
    end
    step(1);

    // timeout with ptr 1 and only requester 0 asking
    bif.req = 4'b0001;
    step(1);
    hi = 0;
    pulse_at = 0;
    pulses = 0;
    while (bif.grant[0] && hi < 20) begin
      hi++;
      if (bif.timeout_pulse) begin
        pulses++;
        pulse_at = hi;
      end
      step(1);
    end
    check_eq("to_grant_len", hi, GRANT_TIMEOUT);
    check_eq("to_pulse_cycle", pulse_at, GRANT_TIMEOUT);
    check_eq("to_pulse_count", pulses, 1);
    check_eq("to_pulse_after", bif.timeout_pulse, 0);
    step(1);
    check_eq("to_ptr", 32'(dut.ptr_q), 1);
    check_eq("to_gap_grant", bif.grant, 0);
    step(1);
    check_eq("to_regrant", bif.grant, 4'b0001);
    bif.req = '0;
    step(2);

    // owner 3 withdraws before accepting
    bif.req = 4'b1000;
    step(1);
    check_eq("wd_grant", bif.grant, 4'b1000);
    check_eq("wd_owner", bif.owner, 3);
    step(1);
    bif.req = '0;
    step(1);
    check_eq("wd_release", bif.grant, 0);
    check_eq("wd_no_timeout", bif.timeout_pulse, 0);
    check_eq("wd_state", 32'(dut.state_q), 3);
    step(1);
    check_eq("wd_ptr_wrap", 32'(dut.ptr_q), 0);

    // legacy master holding the bus blocks arbitration
    bif.bus_busy = 1'b1;
    bif.req      = 4'b0100;
    nz = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (bif.grant != 0) nz++;
    end
    check_eq("busy_no_grant", nz, 0);
    check_eq("busy_not_idle", bif.bus_idle, 0);
    bif.bus_busy = 1'b0;
    step(1);
    check_eq("busy_grant", bif.grant, 4'b0100);
    check_eq("busy_owner", bif.owner, 2);
    bif.req = '0;
    step(2);
    check_eq("busy_ptr", 32'(dut.ptr_q), 3);

    // reset during OWNED while busy stays high
    bif.req = 4'b0010;
    step(1);
    check_eq("ro_grant", bif.grant, 4'b0010);
    bif.bus_busy = 1'b1;
    step(2);
    check_eq("ro_owned", 32'(dut.state_q), 2);
    reset = 1'b0;
    step(1);
    check_eq("ro_grant_rst", bif.grant, 0);
    check_eq("ro_state_rst", 32'(dut.state_q), 0);
    check_eq("ro_owner_rst", bif.owner, 0);
    check_eq("ro_valid_rst", bif.grant_valid, 0);
    check_eq("ro_idle_busy", bif.bus_idle, 0);
    reset = 1'b1;
    nz = 0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (bif.grant != 0) nz++;
    end
    check_eq("ro_no_grant", nz, 0);
    bif.bus_busy = 1'b0;
    step(1);
    check_eq("ro_regrant", bif.grant, 4'b0010);
    bif.req = '0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared memory interconnect. It sequences bus tenure between the instruction cache, data cache and the other bus masters. It issues a one-hot grant to one requester, holds it while that requester drives the wired-OR `bus_busy` line, and withdraws it at the end of the tenure. It then rotates priority to the next requester. It replaces the fixed grant daisy chain as the single source of `grant_in` for every master on the bus.

## Interface
- `NREQ`, default 4: number of requesters. Requester 0 is the icache, 1 the dcache.
- `OWNERW`, default 2: width of the owner index; must satisfy 2^OWNERW >= NREQ.
- `TIMEOUTW`, default 4: width of the grant-acceptance counter.
- `GRANT_TIMEOUT`, default 8: cycles a grant may stay unaccepted before it is revoked. Must be between 2 and 2^TIMEOUTW-1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset. While low, all state returns to reset values at the next edge.
- `req`  in  NREQ  per-requester bus request, level-sensitive.
- `bus_busy`  in  1  wired-OR of all masters' busy outputs. High means the bus is occupied.
- `grant`  out  NREQ  one-hot grant, registered; feeds each master's `grant_in`.
- `grant_valid`  out  1  OR of `grant`.
- `owner`  out  OWNERW  index of the granted or owning requester; valid only when `grant_valid`=1.
- `bus_idle`  out  1  high in IDLE with `bus_busy`=0.
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked for non-acceptance.

## Operation
- State machine with four states.
  - IDLE: waiting for a request.
  - GRANT: grant issued, waiting for acceptance.
  - OWNED: the bus belongs to the owner.
  - RELEASE: one-cycle turnaround.
- Priority pointer `ptr` (OWNERW bits, reset 0).
  - Search order is ptr, ptr+1, …, ptr+NREQ-1, all modulo NREQ.
  - The first index with `req` set wins.
- IDLE:
  - If `bus_busy`=1, stay in IDLE and issue no grant. This covers a legacy master still holding the bus, including across reset.
  - Otherwise, if any `req` bit is set, register the winner into `owner`, set `grant`=one-hot(winner), clear the counter, and go to GRANT.
- GRANT:
  - The counter increments each cycle.
  - If `bus_busy`=1, go to OWNED. The grant stays asserted.
  - Else if `req[owner]`=0, the requester withdrew; go to RELEASE.
  - Else if the counter equals GRANT_TIMEOUT-1, assert `timeout_pulse` and go to RELEASE.
  - Priority when several conditions hold in the same cycle: busy, then withdrawal, then timeout.
- OWNED:
  - The grant is held.
  - `req` changes are ignored; the tenure ends only when `bus_busy` falls to 0. Then go to RELEASE.
  - The tenure length is unbounded; multi-beat line fills, such as the icache's 4-word fill, must not be cut.
- RELEASE:
  - `grant`=0.
  - `ptr` ← (owner+1) mod NREQ. This wraps: with NREQ=4 and owner=3, ptr becomes 0.
  - Next state is always IDLE.
- Exactly zero or one `grant` bit is high at any time.

## Timing
- Reset values: `grant`=0, `grant_valid`=0, `owner`=0, `timeout_pulse`=0, `bus_idle`=1 (if `bus_busy`=0), state=IDLE, `ptr`=0, counter=0.
- Request-to-grant latency: `req` is sampled high in IDLE at edge N, and `grant` is high after edge N. This is 1 cycle.
- Grant is released the cycle after `bus_busy` is sampled low in OWNED (RELEASE).
- The earliest next grant comes 2 cycles after release: the RELEASE cycle, then arbitration in IDLE.
- With constant requests from all masters, consecutive tenures are separated by exactly 2 grant-low cycles.
- Timeout: the grant stays high for exactly GRANT_TIMEOUT cycles. `timeout_pulse` is high during the last of them, coincident with the GRANT→RELEASE transition.
- Reset asserted in any state (including mid-OWNED): all outputs go to reset values at the next edge. The master is responsible for dropping its own `bus_busy`.
- `bus_idle` is combinational from state and `bus_busy`. All other outputs are registered.

## Test plan
- Reset, then `req`=4'b0010 with `bus_busy` low → one cycle later `grant`=4'b0010 and `owner`=1. Drive `bus_busy` high for 4 cycles, then low → grant drops one cycle after busy falls, and `ptr`=2.
- `req`=4'b1111 held constant, with each owner holding busy for 2 cycles → grant order 0,1,2,3,0. Each pair of grants is separated by exactly 2 cycles with `grant`=0.
- `req`=4'b0001, `bus_busy` never asserted, GRANT_TIMEOUT=8 → grant is high for 8 cycles, `timeout_pulse` is high on cycle 8 only, and the next grant goes to requester 0 again only after ptr=1 finds no other request.
- Owner 3 granted; `req[3]` drops on cycle 2 before busy → RELEASE, no `timeout_pulse`, `ptr`=0 (wrap).
- `bus_busy`=1 held with `req`=4'b0100 in IDLE → no grant for as long as busy is high. Grant to requester 2 appears 1 cycle after busy falls.
- Reset asserted low during OWNED while `bus_busy` stays high → the next cycle shows `grant`=0 and state IDLE. No grant is issued until `bus_busy` falls.
